// File: rtl/fx_div16_seq.sv
// rtl/fx_div16_seq.sv - sequential Q1.15 fixed-point divider, O = sat(trunc(A*2^FW / B))
// Optional macro FX_DIV_ROUND_EN: extra guard iteration, round half away from zero.
`timescale 1ns/1ps
module fx_div16_seq #(
    parameter int QW = 12,
    parameter int FW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] A,
    input  logic [15:0]   B,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] O,
    output logic          sat,
    output logic          dz
);

`ifdef FX_DIV_ROUND_EN
    localparam int GB = 1;
`else
    localparam int GB = 0;
`endif
    localparam int DW = QW + FW;
    localparam int N  = DW + GB;
    localparam int CW = $clog2(N);
    localparam logic [DW:0]   POS_LIM = (DW+1)'((1 << (QW-1)) - 1);
    localparam logic [DW:0]   NEG_LIM = (DW+1)'(1 << (QW-1));
    localparam logic [QW-1:0] O_POS   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] O_NEG   = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] dvd;
    logic [15:0]   rem;
    logic [15:0]   dsr;
    logic [N-1:0]  quo;
    logic [CW-1:0] cnt;
    logic          neg;

    logic [QW-1:0] a_mag;
    logic [16:0]   trial;
    logic          ge;
    logic [DW:0]   q_mag;
    logic [QW-1:0] q_low;
    logic [QW-1:0] q_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nxt = (B == 16'd0) ? S_FIX : S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        a_mag = A[QW-1] ? (~A + 1'b1) : A;
        trial = {rem, dvd[DW-1]};
        ge    = (trial >= {1'b0, dsr});
`ifdef FX_DIV_ROUND_EN
        // quo[0] is the first bit below the LSB; adding it rounds the magnitude
        q_mag = {1'b0, quo[N-1:1]} + {{DW{1'b0}}, quo[0]};
`else
        q_mag = {1'b0, quo};
`endif
        q_low    = q_mag[QW-1:0];
        q_signed = neg ? (~q_low + 1'b1) : q_low;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd  <= '0;
            rem  <= '0;
            dsr  <= '0;
            quo  <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            done <= 1'b0;
            O    <= '0;
            sat  <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    neg <= A[QW-1];
                    dvd <= {a_mag, {FW{1'b0}}};
                    dsr <= B;
                    rem <= '0;
                    quo <= '0;
                    cnt <= CW'(N - 1);
                end
                S_CALC: begin
                    dvd <= dvd << 1;
                    rem <= ge ? 16'(trial - {1'b0, dsr}) : trial[15:0];
                    quo <= {quo[N-2:0], ge};
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (dsr == 16'd0) begin
                        O   <= neg ? O_NEG : O_POS;
                        sat <= 1'b1;
                        dz  <= 1'b1;
                    end else if (!neg && q_mag > POS_LIM) begin
                        O   <= O_POS;
                        sat <= 1'b1;
                        dz  <= 1'b0;
                    end else if (neg && q_mag > NEG_LIM) begin
                        O   <= O_NEG;
                        sat <= 1'b1;
                        dz  <= 1'b0;
                    end else begin
                        O   <= q_signed;
                        sat <= 1'b0;
                        dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_div16_seq.sv
// tb/tb_fx_div16_seq.sv - randomized and directed bench for fx_div16_seq against an arithmetic model
`timescale 1ns/1ps
module tb_fx_div16_seq;

`ifdef FX_DIV_ROUND_EN
    localparam int LAT = 29;
`else
    localparam int LAT = 28;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] A = '0;
    logic [15:0] B = '0;
    logic        busy, done, sat, dz;
    logic [11:0] O;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    fx_div16_seq #(.QW(12), .FW(15)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .O(O), .sat(sat), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: exact integer arithmetic on the real-valued quotient
    function automatic void ref_div(input logic [11:0] a, input logic [15:0] b,
                                    output logic [11:0] o, output logic s, output logic z);
        longint sa, mag, q2, q, r;
        sa = longint'($signed(a));
        mag = (sa < 0) ? -sa : sa;
        s = 1'b0;
        z = 1'b0;
        if (b == 16'd0) begin
            z = 1'b1;
            s = 1'b1;
            o = (sa < 0) ? 12'h800 : 12'h7FF;
            return;
        end
        q2 = (mag * 65536) / longint'(b);
`ifdef FX_DIV_ROUND_EN
        q = q2 / 2 + q2 % 2;
`else
        q = q2 / 2;
`endif
        r = (sa < 0) ? -q : q;
        if (r > 2047) begin
            o = 12'h7FF;
            s = 1'b1;
        end else if (r < -2048) begin
            o = 12'h800;
            s = 1'b1;
        end else begin
            o = r[11:0];
        end
    endfunction

    logic        pend = 1'b0;
    int          p_due = 0;
    logic [11:0] p_O, m_O = '0;
    logic        p_sat, p_dz;
    logic        m_sat = 1'b0, m_dz = 1'b0, m_done = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic [11:0] t_o;
        logic        t_s, t_z;
        if (rst) begin
            pend   <= 1'b0;
            m_O    <= '0;
            m_sat  <= 1'b0;
            m_dz   <= 1'b0;
            m_done <= 1'b0;
        end else begin
            cyc    <= cyc + 1;
            m_done <= 1'b0;
            if (pend && (cyc + 1 == p_due)) begin
                m_O    <= p_O;
                m_sat  <= p_sat;
                m_dz   <= p_dz;
                m_done <= 1'b1;
                pend   <= 1'b0;
            end
            if (!pend && start) begin
                ref_div(A, B, t_o, t_s, t_z);
                p_O   <= t_o;
                p_sat <= t_s;
                p_dz  <= t_z;
                p_due <= cyc + 1 + ((B == 16'd0) ? 1 : LAT);
                pend  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_busy", busy, pend);
            chk("mon_done", done, m_done);
            chk("mon_O", O, m_O);
            chk("mon_sat", sat, m_sat);
            chk("mon_dz", dz, m_dz);
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    endtask

    task automatic wait_done(input string nm, input int k, input logic [11:0] eo,
                             input logic es, input logic ez, input int elat);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_done_seen"}, got, 1);
        if (got) begin
            chk({nm, "_latency"}, cyc - k, elat);
            chk({nm, "_O"}, O, eo);
            chk({nm, "_sat"}, sat, es);
            chk({nm, "_dz"}, dz, ez);
        end
    endtask

    task automatic run_lit(input string nm, input logic [11:0] a, input logic [15:0] b,
                           input logic [11:0] eo, input logic es, input logic ez, input int elat);
        int k;
        wait_idle();
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        k = cyc;
        @(negedge clk);
        start = 1'b0; A = 12'($urandom); B = 16'($urandom);
        wait_done(nm, k, eo, es, ez, elat);
    endtask

    logic [11:0] pin_o;
    logic        pin_s, pin_z;

    initial begin
        int k;
        bit saw;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_O", O, 0);
        chk("rst_sat", sat, 0);
        chk("rst_dz", dz, 0);
        mon_en = 1'b1;

        ref_div(12'h100, 16'h4000, pin_o, pin_s, pin_z);
        chk("pin_model_0", {pin_z, pin_s, pin_o}, {2'b00, 12'h200});
        ref_div(12'hBFF, 16'h4000, pin_o, pin_s, pin_z);
        chk("pin_model_1", {pin_z, pin_s, pin_o}, {2'b01, 12'h800});
        ref_div(12'hFFF, 16'h0000, pin_o, pin_s, pin_z);
        chk("pin_model_2", {pin_z, pin_s, pin_o}, {2'b11, 12'h800});

        run_lit("pos_half", 12'h100, 16'h4000, 12'h200, 0, 0, LAT);
        run_lit("neg_half", 12'hF00, 16'h4000, 12'hE00, 0, 0, LAT);
        run_lit("unity",    12'h5D4, 16'h8000, 12'h5D4, 0, 0, LAT);
        run_lit("sat_pos",  12'h400, 16'h4000, 12'h7FF, 1, 0, LAT);
        run_lit("neg_edge", 12'hC00, 16'h4000, 12'h800, 0, 0, LAT);
        run_lit("sat_neg",  12'hBFF, 16'h4000, 12'h800, 1, 0, LAT);
        run_lit("dz_pos",   12'h123, 16'h0000, 12'h7FF, 1, 1, 1);
        run_lit("dz_neg",   12'hFFF, 16'h0000, 12'h800, 1, 1, 1);
        run_lit("one_third", 12'h001, 16'h6000, 12'h001, 0, 0, LAT);
`ifdef FX_DIV_ROUND_EN
        run_lit("two_third", 12'h002, 16'h6000, 12'h003, 0, 0, LAT);
        run_lit("max_div",   12'h7FF, 16'hFFFF, 12'h400, 0, 0, LAT);
`else
        run_lit("two_third", 12'h002, 16'h6000, 12'h002, 0, 0, LAT);
        run_lit("max_div",   12'h7FF, 16'hFFFF, 12'h3FF, 0, 0, LAT);
`endif

        // second start while busy must be dropped
        wait_idle();
        @(negedge clk);
        start = 1'b1; A = 12'h100; B = 16'h4000;
        @(posedge clk); #1;
        k = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; A = 12'h7FF; B = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", k, 12'h200, 0, 0, LAT);

        // reset mid-operation aborts with no done pulse
        wait_idle();
        @(negedge clk);
        start = 1'b1; A = 12'h300; B = 16'h8000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        saw = 1'b0;
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("abort_no_done", saw, 0);
        run_lit("after_abort", 12'h300, 16'h8000, 12'h300, 0, 0, LAT);

        // randomized traffic, checked every cycle by the monitor
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            A     = 12'($urandom);
            case ($urandom_range(0, 7))
                0:       B = 16'h0000;
                1, 2:    B = 16'($urandom_range(1, 255));
                3:       B = 16'h8000;
                default: B = 16'($urandom);
            endcase
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
